// File: rtl/dff_scoreboard_if.sv
// ---------------------------------------------------------------------------
// dff_scoreboard_if
//
// Bundles the control, stimulus and status signals of dff_scoreboard so the
// scoreboard can be dropped next to the DFF stage with a single connection.
//
//   start          one-cycle pulse: clear everything and begin a run
//   num_checks     number of compares for the run, sampled with start
//   exp_valid      exp_data is the value driven onto the DFF D input
//   exp_data       expected value, pushed into the scoreboard FIFO
//   obs_valid      obs_data is a sampled DFF Q to compare this cycle
//   obs_data       observed DFF Q value
//   busy / done    run in progress / run complete
//   pass           run complete with no mismatch, overflow or underflow
//   match_cnt      saturating count of equal compares
//   mismatch_cnt   saturating count of unequal compares
//   overflow       sticky: push attempted while the FIFO was full
//   underflow      sticky: observation arrived while the FIFO was empty
//   first_err_*    index, expected and observed value of the first mismatch
//
// Modports: master drives stimulus and reads status (bench / bring-up
// logic); slave is the scoreboard itself. DATA_W and CNT_W must match the
// values used on the dff_scoreboard instance.
// ---------------------------------------------------------------------------
interface dff_scoreboard_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  num_checks;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;

    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic              overflow;
    logic              underflow;
    logic [CNT_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_obs;

    modport master (
        output start, num_checks, exp_valid, exp_data, obs_valid, obs_data,
        input  busy, done, pass, match_cnt, mismatch_cnt, overflow, underflow,
               first_err_idx, first_err_exp, first_err_obs
    );

    modport slave (
        input  start, num_checks, exp_valid, exp_data, obs_valid, obs_data,
        output busy, done, pass, match_cnt, mismatch_cnt, overflow, underflow,
               first_err_idx, first_err_exp, first_err_obs
    );
endinterface

// File: rtl/dff_scoreboard.sv
// ---------------------------------------------------------------------------
// dff_scoreboard
//
// In-order hardware scoreboard for the D flip-flop stage. Every value driven
// onto D is pushed into a small expected-value FIFO; every sampled Q pops the
// head and is compared against it. Match/mismatch counts, sticky
// overflow/underflow flags and the details of the first mismatch are kept,
// and the run finishes after a programmed number of compares.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (highest priority)
//   sb    dff_scoreboard_if.slave: start/num_checks, exp_*/obs_* stimulus,
//         busy/done/pass and the result counters and flags
//
// Parameters:
//   DATA_W  width of the compared D/Q data
//   DEPTH   expected-FIFO entries (power of two, >= 2)
//   CNT_W   width of the counters and of num_checks
// ---------------------------------------------------------------------------
module dff_scoreboard #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    dff_scoreboard_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    // One extra state beyond DEPTH so full and empty never alias.
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  checks_done_q, checks_done_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
    logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
    logic [DATA_W-1:0] first_err_obs_q, first_err_obs_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // FIFO status and the per-cycle push/pop decisions.
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic              do_push;
    logic              do_pop;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_head  = mem_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here starts from a default so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        target_d        = target_q;
        checks_done_d   = checks_done_q;
        match_cnt_d     = match_cnt_q;
        mismatch_cnt_d  = mismatch_cnt_q;
        overflow_d      = overflow_q;
        underflow_d     = underflow_q;
        first_err_idx_d = first_err_idx_q;
        first_err_exp_d = first_err_exp_q;
        first_err_obs_d = first_err_obs_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        do_push         = 1'b0;
        do_pop          = 1'b0;

        if (sb.start) begin
            // start works from any state and wins over the stimulus inputs
            // of the same cycle: the run begins on a clean slate.
            target_d        = sb.num_checks;
            checks_done_d   = '0;
            match_cnt_d     = '0;
            mismatch_cnt_d  = '0;
            overflow_d      = 1'b0;
            underflow_d     = 1'b0;
            first_err_idx_d = '0;
            first_err_exp_d = '0;
            first_err_obs_d = '0;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            occ_d           = '0;
            // A zero-length run has nothing to compare and completes at once.
            state_d         = (sb.num_checks == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN) begin
            // No bypass: an observation against an empty FIFO never sees the
            // value being pushed in the same cycle.
            do_pop  = sb.obs_valid && !fifo_empty;
            // A full FIFO still accepts a push when the head leaves this
            // cycle, so occupancy stays at DEPTH.
            do_push = sb.exp_valid && (!fifo_full || do_pop);

            if (sb.exp_valid && !do_push) begin
                overflow_d = 1'b1;
            end
            if (sb.obs_valid && fifo_empty) begin
                underflow_d = 1'b1;
            end

            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (do_pop) begin
                rd_ptr_d      = rd_ptr_q + 1'b1;
                checks_done_d = checks_done_q + 1'b1;
                if (fifo_head == sb.obs_data) begin
                    if (match_cnt_q != CNT_MAX) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else begin
                    if (mismatch_cnt_q != CNT_MAX) begin
                        mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                    end
                    // mismatch_cnt saturates rather than wraps, so a zero
                    // count marks this compare as the first mismatch.
                    if (mismatch_cnt_q == '0) begin
                        first_err_idx_d = checks_done_q;
                        first_err_exp_d = fifo_head;
                        first_err_obs_d = sb.obs_data;
                    end
                end
            end

            occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);

            // Leaving RUN on the edge of the final compare makes done visible
            // the following cycle, exactly when busy drops.
            if (checks_done_d == target_q) begin
                state_d = ST_DONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q         <= ST_IDLE;
            target_q        <= '0;
            checks_done_q   <= '0;
            match_cnt_q     <= '0;
            mismatch_cnt_q  <= '0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            first_err_idx_q <= '0;
            first_err_exp_q <= '0;
            first_err_obs_q <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            checks_done_q   <= checks_done_d;
            match_cnt_q     <= match_cnt_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_obs_q <= first_err_obs_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever read after
    // it has been written, and leaving it out lets the array map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= sb.exp_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded directly from registers)
    // -----------------------------------------------------------------------
    assign sb.busy          = (state_q == ST_RUN);
    assign sb.done          = (state_q == ST_DONE);
    assign sb.pass          = (state_q == ST_DONE) && (mismatch_cnt_q == '0) &&
                              !overflow_q && !underflow_q;
    assign sb.match_cnt     = match_cnt_q;
    assign sb.mismatch_cnt  = mismatch_cnt_q;
    assign sb.overflow      = overflow_q;
    assign sb.underflow     = underflow_q;
    assign sb.first_err_idx = first_err_idx_q;
    assign sb.first_err_exp = first_err_exp_q;
    assign sb.first_err_obs = first_err_obs_q;

endmodule

// File: tb/tb_dff_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_dff_scoreboard
//
// Directed bench for dff_scoreboard: clean DFF run, single corruption,
// overflow with push/pop on a full FIFO, underflow with push/pop on an empty
// FIFO, pointer wrap-around, and reset mid-run followed by a zero-length run.
// ---------------------------------------------------------------------------
module tb_dff_scoreboard;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dff_scoreboard_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    dff_scoreboard #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    int checks = 0;
    int errors = 0;

    // {busy, done, pass, overflow, underflow}
    logic [4:0] flags;
    assign flags = {bus.busy, bus.done, bus.pass, bus.overflow, bus.underflow};

    // Values driven onto D in the DFF runs; entry 4 is 4'h3.
    logic [3:0] vec [10] = '{4'h1, 4'h2, 4'h9, 4'h6, 4'h3,
                             4'h8, 4'h0, 4'hE, 4'h5, 4'hB};

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ev, input logic [3:0] ed,
                        input logic ov, input logic [3:0] od);
        bus.exp_valid = ev;
        bus.exp_data  = ed;
        bus.obs_valid = ov;
        bus.obs_data  = od;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        bus.start      = 1'b1;
        bus.num_checks = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    function automatic logic [3:0] wrap_val(input int k);
        return 4'(k * 5 + 1);
    endfunction

    // Ten pushes through a one-cycle DFF model; Q of check `bad` is forced
    // to 4'hF. Returns flags and mismatch count sampled right after check 4.
    task automatic run_dff(input int bad, output logic [4:0] mid_flags,
                           output logic [7:0] mid_mis);
        logic [3:0] q;
        logic [3:0] od;
        logic [3:0] ed;
        q = 4'h0;
        mid_flags = '0;
        mid_mis = '0;
        do_start(8'd10);
        for (int k = 0; k <= 10; k++) begin
            od = (k - 1 == bad) ? 4'hF : q;
            if (k < 10) ed = vec[k];
            else        ed = 4'h0;
            step(k < 10, ed, k > 0, od);
            if (k < 10) q = vec[k];
            if (k == 5) begin
                mid_flags = flags;
                mid_mis   = bus.mismatch_cnt;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 4'h0, 1'b0, 4'h0);
        step(1'b0, 4'h0, 1'b0, 4'h0);
        rst = 1'b0;
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b want %b", flags, 5'b00000);
        end
        checks++;
        if ({bus.match_cnt, bus.mismatch_cnt, bus.first_err_idx} !== 24'h0) begin
            errors++;
            $display("FAIL reset_counts: got %h want 0",
                     {bus.match_cnt, bus.mismatch_cnt, bus.first_err_idx});
        end
        checks++;
        if ({bus.first_err_exp, bus.first_err_obs} !== 8'h00) begin
            errors++;
            $display("FAIL reset_err_data: got %h want 00",
                     {bus.first_err_exp, bus.first_err_obs});
        end
    endtask

    task automatic test_clean();
        logic [4:0] mf;
        logic [7:0] mm;
        run_dff(-1, mf, mm);
        checks++;
        if (mf !== 5'b10000) begin
            errors++;
            $display("FAIL clean_mid_flags: got %b want %b", mf, 5'b10000);
        end
        checks++;
        if (bus.match_cnt !== 8'd10) begin
            errors++;
            $display("FAIL clean_match: got %0d want 10", bus.match_cnt);
        end
        checks++;
        if (bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clean_mismatch: got %0d want 0", bus.mismatch_cnt);
        end
        checks++;
        if (flags !== 5'b01100) begin
            errors++;
            $display("FAIL clean_done_flags: got %b want %b", flags, 5'b01100);
        end
        // DONE ignores stimulus and holds its outputs.
        step(1'b1, 4'h4, 1'b1, 4'h4);
        checks++;
        if ({flags, bus.match_cnt} !== {5'b01100, 8'd10}) begin
            errors++;
            $display("FAIL clean_done_hold: got %b/%0d want 01100/10",
                     flags, bus.match_cnt);
        end
    endtask

    task automatic test_corrupt();
        logic [4:0] mf;
        logic [7:0] mm;
        run_dff(4, mf, mm);
        checks++;
        if (mm !== 8'd1) begin
            errors++;
            $display("FAIL corrupt_same_edge: got %0d want 1", mm);
        end
        checks++;
        if (bus.match_cnt !== 8'd9 || bus.mismatch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL corrupt_counts: got %0d/%0d want 9/1",
                     bus.match_cnt, bus.mismatch_cnt);
        end
        checks++;
        if (bus.first_err_idx !== 8'd4) begin
            errors++;
            $display("FAIL corrupt_idx: got %0d want 4", bus.first_err_idx);
        end
        checks++;
        if (bus.first_err_exp !== 4'h3 || bus.first_err_obs !== 4'hF) begin
            errors++;
            $display("FAIL corrupt_err_data: got exp %h obs %h want 3 F",
                     bus.first_err_exp, bus.first_err_obs);
        end
        checks++;
        if (flags !== 5'b01000) begin
            errors++;
            $display("FAIL corrupt_flags: got %b want %b", flags, 5'b01000);
        end
    endtask

    task automatic test_overflow();
        do_start(8'd10);
        for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 4'h0);
        checks++;
        if (flags !== 5'b10000) begin
            errors++;
            $display("FAIL ovf_exact_full: got %b want %b", flags, 5'b10000);
        end
        step(1'b1, 4'h9, 1'b0, 4'h0);   // dropped
        checks++;
        if (flags !== 5'b10010) begin
            errors++;
            $display("FAIL ovf_flag: got %b want %b", flags, 5'b10010);
        end
        // Push and pop together while full: both happen.
        step(1'b1, 4'hA, 1'b1, 4'h1);
        checks++;
        if (bus.match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovf_full_pushpop: got %0d want 1", bus.match_cnt);
        end
        for (int v = 2; v <= 8; v++) step(1'b0, 4'h0, 1'b1, 4'(v));
        step(1'b0, 4'h0, 1'b1, 4'hA);
        checks++;
        if (bus.match_cnt !== 8'd9 || bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ovf_drain: got %0d/%0d want 9/0",
                     bus.match_cnt, bus.mismatch_cnt);
        end
        // Occupancy must now be zero.
        step(1'b0, 4'h0, 1'b1, 4'h0);
        checks++;
        if (flags !== 5'b10011 || bus.match_cnt !== 8'd9 ||
            bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ovf_then_empty: got %b %0d/%0d want 10011 9/0",
                     flags, bus.match_cnt, bus.mismatch_cnt);
        end
    endtask

    task automatic test_underflow();
        // Restart from RUN; stimulus in the start cycle must be ignored.
        bus.exp_valid = 1'b1;
        bus.exp_data  = 4'h5;
        bus.obs_valid = 1'b1;
        bus.obs_data  = 4'h5;
        do_start(8'd1);
        checks++;
        if (flags !== 5'b10000 || bus.match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL unf_restart: got %b %0d want 10000 0",
                     flags, bus.match_cnt);
        end
        step(1'b0, 4'h0, 1'b1, 4'h5);
        checks++;
        if (flags !== 5'b10001 || bus.match_cnt !== 8'd0 ||
            bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL unf_flag: got %b %0d/%0d want 10001 0/0",
                     flags, bus.match_cnt, bus.mismatch_cnt);
        end
        step(1'b1, 4'h7, 1'b1, 4'h7);
        checks++;
        if (bus.match_cnt !== 8'd0 || bus.mismatch_cnt !== 8'd0 ||
            flags !== 5'b10001) begin
            errors++;
            $display("FAIL unf_no_bypass: got %b %0d/%0d want 10001 0/0",
                     flags, bus.match_cnt, bus.mismatch_cnt);
        end
        step(1'b0, 4'h0, 1'b1, 4'h7);
        checks++;
        if (bus.match_cnt !== 8'd1 || flags !== 5'b01001) begin
            errors++;
            $display("FAIL unf_stored: got %b %0d want 01001 1",
                     flags, bus.match_cnt);
        end
    endtask

    task automatic test_wrap();
        do_start(8'd20);
        for (int k = 0; k < 3; k++) step(1'b1, wrap_val(k), 1'b0, 4'h0);
        for (int j = 0; j < 20; j++) begin
            step(1'b1, wrap_val(j + 3), 1'b1, wrap_val(j));
            if (j == 18) begin
                checks++;
                if (bus.match_cnt !== 8'd19 || flags !== 5'b10000) begin
                    errors++;
                    $display("FAIL wrap_mid: got %b %0d want 10000 19",
                             flags, bus.match_cnt);
                end
            end
        end
        checks++;
        if (bus.match_cnt !== 8'd20 || bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_counts: got %0d/%0d want 20/0",
                     bus.match_cnt, bus.mismatch_cnt);
        end
        checks++;
        if (flags !== 5'b01100) begin
            errors++;
            $display("FAIL wrap_flags: got %b want %b", flags, 5'b01100);
        end
    endtask

    task automatic test_reset_restart();
        do_start(8'd10);
        step(1'b1, 4'h2, 1'b0, 4'h0);
        // Pops compare 2,3,4,5,6; check 2 is corrupted to 4'hC.
        for (int j = 0; j < 5; j++)
            step(1'b1, 4'(j + 3), 1'b1, (j == 2) ? 4'hC : 4'(j + 2));
        checks++;
        if (bus.match_cnt !== 8'd4 || bus.mismatch_cnt !== 8'd1 ||
            bus.first_err_idx !== 8'd2 || flags !== 5'b10000) begin
            errors++;
            $display("FAIL rst_pre: got %b %0d/%0d idx %0d want 10000 4/1 idx 2",
                     flags, bus.match_cnt, bus.mismatch_cnt, bus.first_err_idx);
        end
        rst = 1'b1;
        step(1'b0, 4'h0, 1'b0, 4'h0);
        rst = 1'b0;
        checks++;
        if (flags !== 5'b00000 || bus.match_cnt !== 8'd0 ||
            bus.mismatch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_run: got %b %0d/%0d want 00000 0/0",
                     flags, bus.match_cnt, bus.mismatch_cnt);
        end
        checks++;
        if ({bus.first_err_idx, bus.first_err_exp, bus.first_err_obs} !== 16'h0) begin
            errors++;
            $display("FAIL rst_err_clear: got %h want 0",
                     {bus.first_err_idx, bus.first_err_exp, bus.first_err_obs});
        end
        // IDLE ignores stimulus.
        step(1'b1, 4'h3, 1'b1, 4'h3);
        checks++;
        if (flags !== 5'b00000 || bus.match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL idle_ignore: got %b %0d want 00000 0",
                     flags, bus.match_cnt);
        end
        step(1'b0, 4'h0, 1'b0, 4'h0);
        do_start(8'd0);
        checks++;
        if (flags !== 5'b01100) begin
            errors++;
            $display("FAIL zero_checks: got %b want %b", flags, 5'b01100);
        end
        step(1'b1, 4'h1, 1'b1, 4'h1);
        checks++;
        if (flags !== 5'b01100 || bus.match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL zero_hold: got %b %0d want 01100 0",
                     flags, bus.match_cnt);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_checks = '0;
        bus.exp_valid  = 1'b0;
        bus.exp_data   = '0;
        bus.obs_valid  = 1'b0;
        bus.obs_data   = '0;

        test_reset();
        test_clean();
        test_corrupt();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_restart();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_scoreboard.md
Name: dff_scoreboard

Overview:
- Synthesizable in-order scoreboard that sits directly downstream of the 4-bit D flip-flop stage, with data width parameterized.
- Captures each value driven onto D into an expected-value FIFO.
- Pops and compares against each sampled Q value; keeps match/mismatch counts and first-failure details.
- Flags done after a programmed number of comparisons, replacing queue-based checking with hardware usable in both simulation and FPGA bring-up.

Parameters:
- DATA_W, 4, width of D/Q data compared.
- DEPTH, 8, expected-FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of counters and check-count target.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; clears counters, flags and FIFO, then enters RUN.
- num_checks  input  CNT_W  comparisons to perform; sampled on start.
- exp_valid  input  1  push exp_data into FIFO this cycle.
- exp_data  input  DATA_W  value driven onto the DFF D input.
- obs_valid  input  1  obs_data is a sampled Q to compare this cycle.
- obs_data  input  DATA_W  DFF Q output.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  done & no mismatch & no overflow & no underflow.
- match_cnt  output  CNT_W  saturating match count.
- mismatch_cnt  output  CNT_W  saturating mismatch count.
- overflow  output  1  sticky; push attempted while FIFO full.
- underflow  output  1  sticky; obs_valid while FIFO empty.
- first_err_idx  output  CNT_W  check index (0-based) of the first mismatch.
- first_err_exp  output  DATA_W  expected value at the first mismatch.
- first_err_obs  output  DATA_W  observed value at the first mismatch.

Behaviour:
- Reset: applies on a clk edge with rst=1 and has priority over everything. State=IDLE, FIFO empty, all outputs 0.
- FSM: IDLE -start-> RUN; RUN -(checks_done==target)-> DONE; DONE -start-> RUN.
- start in RUN restarts: clears state and re-samples num_checks.
- start with num_checks=0 goes directly to DONE next cycle, with pass=1.
- exp_valid/obs_valid are ignored outside RUN, and in the start cycle itself.
- Push: in RUN with exp_valid=1 and FIFO not full, write at wr_ptr; wr_ptr wraps modulo DEPTH.
- Push when full: data dropped, overflow<=1.
- Full with simultaneous push and pop: both occur, and occupancy is unchanged.
- Pop/compare: in RUN with obs_valid=1 and FIFO not empty:
  - Read head, compare with obs_data, advance rd_ptr, increment checks_done.
  - Equal: match_cnt++. Unequal: mismatch_cnt++.
- First mismatch only: capture first_err_idx=checks_done (pre-increment), first_err_exp and first_err_obs.
- Empty with simultaneous push and pop: no bypass. underflow<=1, no compare, checks_done unchanged, pushed value stored.
- Counters saturate at 2^CNT_W-1; checks_done stops at the target.
- Comparison latency:
  - Counters, flags and first_err_* update on the same clk edge as the obs_valid sample.
  - done/pass are valid the cycle after the final compare; busy falls the same cycle.
- Occupancy uses a DEPTH+1-state counter (or an extra pointer bit) so full and empty are unambiguous.
- Reset mid-RUN discards all contents and returns to IDLE.
- DONE holds every output stable until start or rst.

Test Plan:
- Clean run: rst, start with num_checks=10. Push 10 values while the DFF model delays by one cycle, and present each Q. Expect match_cnt=10, mismatch_cnt=0, done=1, pass=1.
- Single corruption: same run with obs_data forced to 4'hF instead of 4'h3 on check 4. Expect mismatch_cnt=1, match_cnt=9, first_err_idx=4, first_err_exp=3, first_err_obs=F, pass=0.
- Overflow: DEPTH=8, push 9 values with no obs. Expect overflow=1 and an occupancy of 8. Then 8 obs of the first 8 values give match_cnt=8.
- Underflow and simultaneous push/pop on empty: obs_valid on an empty FIFO, then exp_valid+obs_valid together while empty. Expect underflow=1, match_cnt=0, and occupancy 1 afterwards.
- Wrap-around: 20 interleaved push/pop pairs with occupancy held at 3. Expect match_cnt=20 with rd_ptr/wr_ptr wrapped twice, and no flags.
- Reset and restart: rst asserted mid-RUN after 5 checks returns all outputs to 0 and state to IDLE. A new start with num_checks=0 gives done=1, pass=1 one cycle later.
